// File: rtl/idu_is_pkg.sv
// Shared defaults for the IS-stage issue queue: field widths and the layout
// of the opaque payload packed by dispatch.
package idu_is_pkg;

    localparam int DEF_PREG_W    = 6;
    localparam int DEF_IID_W     = 4;
    localparam int DEF_PAYLOAD_W = 145;

    // pc bit 0 is always zero for aligned fetch, so only pc[63:1] is carried.
    localparam int PL_OPCODE_LSB = 0;
    localparam int PL_OPCODE_W   = 7;
    localparam int PL_FUNCT7_LSB = 7;
    localparam int PL_FUNCT7_W   = 7;
    localparam int PL_FUNCT3_LSB = 14;
    localparam int PL_FUNCT3_W   = 3;
    localparam int PL_IMMVLD_BIT = 17;
    localparam int PL_IMM_LSB    = 18;
    localparam int PL_IMM_W      = 64;
    localparam int PL_PC_LSB     = 82;
    localparam int PL_PC_W       = 63;

endpackage

// File: rtl/idu_is_iq_slot.sv
// One issue-queue entry: stored fields, per-source wakeup comparators against
// every broadcast port, and the entry-ready output.
module idu_is_iq_slot
    import idu_is_pkg::*;
#(
    parameter int WAKE_PORTS = 10,
    parameter int PREG_W     = DEF_PREG_W,
    parameter int IID_W      = DEF_IID_W,
    parameter int PAYLOAD_W  = DEF_PAYLOAD_W
) (
    input  logic                         clk,
    input  logic                         rst_clk,
    input  logic                         i_flush,
    input  logic                         i_create,
    input  logic                         i_clear,
    input  logic [IID_W-1:0]             i_iid,
    input  logic [PAYLOAD_W-1:0]         i_payload,
    input  logic                         i_psrc1_vld,
    input  logic                         i_psrc1_ready,
    input  logic [PREG_W-1:0]            i_psrc1,
    input  logic                         i_psrc2_vld,
    input  logic                         i_psrc2_ready,
    input  logic [PREG_W-1:0]            i_psrc2,
    input  logic                         i_pdst_vld,
    input  logic [PREG_W-1:0]            i_pdst,
    input  logic [WAKE_PORTS-1:0]        i_wake_vld,
    input  logic [WAKE_PORTS*PREG_W-1:0] i_wake_preg,
    output logic                         o_vld,
    output logic                         o_ready,
    output logic [IID_W-1:0]             o_iid,
    output logic [PAYLOAD_W-1:0]         o_payload,
    output logic [PREG_W-1:0]            o_psrc1,
    output logic [PREG_W-1:0]            o_psrc2,
    output logic                         o_pdst_vld,
    output logic [PREG_W-1:0]            o_pdst
);

    logic                 r_vld;
    logic [IID_W-1:0]     r_iid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic                 r_psrc1_vld, r_psrc1_ready;
    logic                 r_psrc2_vld, r_psrc2_ready;
    logic [PREG_W-1:0]    r_psrc1, r_psrc2;
    logic                 r_pdst_vld;
    logic [PREG_W-1:0]    r_pdst;

    logic w_hit1, w_hit2, w_chit1, w_chit2;

    // Stored sources match against held pregs; create sources against the incoming ones.
    always_comb begin
        w_hit1  = 1'b0;
        w_hit2  = 1'b0;
        w_chit1 = 1'b0;
        w_chit2 = 1'b0;
        for (int k = 0; k < WAKE_PORTS; k++) begin
            if (i_wake_vld[k]) begin
                if (i_wake_preg[k*PREG_W +: PREG_W] == r_psrc1) w_hit1  = 1'b1;
                if (i_wake_preg[k*PREG_W +: PREG_W] == r_psrc2) w_hit2  = 1'b1;
                if (i_wake_preg[k*PREG_W +: PREG_W] == i_psrc1) w_chit1 = 1'b1;
                if (i_wake_preg[k*PREG_W +: PREG_W] == i_psrc2) w_chit2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk || i_flush || (i_clear && !i_create)) begin
            r_vld         <= 1'b0;
            r_iid         <= '0;
            r_payload     <= '0;
            r_psrc1_vld   <= 1'b0;
            r_psrc1_ready <= 1'b0;
            r_psrc1       <= '0;
            r_psrc2_vld   <= 1'b0;
            r_psrc2_ready <= 1'b0;
            r_psrc2       <= '0;
            r_pdst_vld    <= 1'b0;
            r_pdst        <= '0;
        end else if (i_create) begin
            r_vld         <= 1'b1;
            r_iid         <= i_iid;
            r_payload     <= i_payload;
            r_psrc1_vld   <= i_psrc1_vld;
            r_psrc1_ready <= i_psrc1_ready | w_chit1;
            r_psrc1       <= i_psrc1;
            r_psrc2_vld   <= i_psrc2_vld;
            r_psrc2_ready <= i_psrc2_ready | w_chit2;
            r_psrc2       <= i_psrc2;
            r_pdst_vld    <= i_pdst_vld;
            r_pdst        <= i_pdst_vld ? i_pdst : '0;
        end else if (r_vld) begin
            r_psrc1_ready <= r_psrc1_ready | w_hit1;
            r_psrc2_ready <= r_psrc2_ready | w_hit2;
        end
    end

    assign o_vld      = r_vld;
    assign o_ready    = r_vld & (r_psrc1_ready | ~r_psrc1_vld) & (r_psrc2_ready | ~r_psrc2_vld);
    assign o_iid      = r_iid;
    assign o_payload  = r_payload;
    assign o_psrc1    = r_psrc1;
    assign o_psrc2    = r_psrc2;
    assign o_pdst_vld = r_pdst_vld;
    assign o_pdst     = r_pdst;

endmodule

// File: rtl/idu_is_iq.sv
// IS-stage issue queue: DEPTH slots, lowest-free allocation, age-matrix
// oldest-ready select and one issue per cycle.
module idu_is_iq
    import idu_is_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WAKE_PORTS = 10,
    parameter int PREG_W     = DEF_PREG_W,
    parameter int IID_W      = DEF_IID_W,
    parameter int PAYLOAD_W  = DEF_PAYLOAD_W,
    parameter int CNT_W      = $clog2(DEPTH+1)
) (
    input  logic                         clk,
    input  logic                         rst_clk,
    input  logic                         rtu_global_flush,
    input  logic                         create_vld,
    output logic                         create_rdy,
    input  logic [IID_W-1:0]             create_iid,
    input  logic [PAYLOAD_W-1:0]         create_payload,
    input  logic                         create_psrc1_vld,
    input  logic                         create_psrc2_vld,
    input  logic                         create_psrc1_ready,
    input  logic                         create_psrc2_ready,
    input  logic [PREG_W-1:0]            create_psrc1,
    input  logic [PREG_W-1:0]            create_psrc2,
    input  logic                         create_pdst_vld,
    input  logic [PREG_W-1:0]            create_pdst,
    input  logic [WAKE_PORTS-1:0]        wake_vld,
    input  logic [WAKE_PORTS*PREG_W-1:0] wake_preg,
    input  logic                         issue_en,
    output logic                         issue_vld,
    output logic [IID_W-1:0]             issue_iid,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [PREG_W-1:0]            issue_psrc1,
    output logic [PREG_W-1:0]            issue_psrc2,
    output logic                         issue_pdst_vld,
    output logic [PREG_W-1:0]            issue_pdst,
    output logic [CNT_W-1:0]             entry_cnt,
    output logic                         empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]     w_vld, w_ready, w_alloc, w_sel;
    logic [IID_W-1:0]     w_iid     [DEPTH];
    logic [PAYLOAD_W-1:0] w_payload [DEPTH];
    logic [PREG_W-1:0]    w_psrc1   [DEPTH];
    logic [PREG_W-1:0]    w_psrc2   [DEPTH];
    logic [PREG_W-1:0]    w_pdst    [DEPTH];
    logic [DEPTH-1:0]     w_pdst_vld;
    logic                 w_create_fire, w_issue_fire;

    logic [DEPTH-1:0]     r_age [DEPTH];
    logic [CNT_W-1:0]     r_cnt;

    // Handshakes: a create transfers when create_vld && create_rdy at a rising
    // edge; an issue transfers when issue_vld && issue_en. Flush cancels both.
    assign create_rdy    = (r_cnt != FULL_CNT);
    assign w_create_fire = create_vld & create_rdy & ~rtu_global_flush;
    assign w_issue_fire  = issue_vld & issue_en & ~rtu_global_flush;
    assign w_alloc       = ~w_vld & (w_vld + DEPTH'(1));

    // An entry is picked only if no other ready entry is older than it.
    always_comb begin
        w_sel = w_ready;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (w_ready[j] && r_age[j][i]) w_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        issue_iid      = '0;
        issue_payload  = '0;
        issue_psrc1    = '0;
        issue_psrc2    = '0;
        issue_pdst_vld = 1'b0;
        issue_pdst     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                issue_iid      = issue_iid      | w_iid[i];
                issue_payload  = issue_payload  | w_payload[i];
                issue_psrc1    = issue_psrc1    | w_psrc1[i];
                issue_psrc2    = issue_psrc2    | w_psrc2[i];
                issue_pdst_vld = issue_pdst_vld | w_pdst_vld[i];
                issue_pdst     = issue_pdst     | w_pdst[i];
            end
        end
    end

    assign issue_vld = |w_ready;
    assign entry_cnt = r_cnt;
    assign empty     = (r_cnt == '0);

    // The new slot becomes younger than every currently valid entry.
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else if (rtu_global_flush) begin
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else if (w_create_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (w_alloc[i])      r_age[i][j] <= 1'b0;
                    else if (w_alloc[j]) r_age[i][j] <= w_vld[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk)              r_cnt <= '0;
        else if (rtu_global_flush) r_cnt <= '0;
        else                       r_cnt <= r_cnt + CNT_W'(w_create_fire) - CNT_W'(w_issue_fire);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        idu_is_iq_slot #(
            .WAKE_PORTS (WAKE_PORTS),
            .PREG_W     (PREG_W),
            .IID_W      (IID_W),
            .PAYLOAD_W  (PAYLOAD_W)
        ) u_slot (
            .clk           (clk),
            .rst_clk       (rst_clk),
            .i_flush       (rtu_global_flush),
            .i_create      (w_create_fire & w_alloc[g]),
            .i_clear       (w_issue_fire & w_sel[g]),
            .i_iid         (create_iid),
            .i_payload     (create_payload),
            .i_psrc1_vld   (create_psrc1_vld),
            .i_psrc1_ready (create_psrc1_ready),
            .i_psrc1       (create_psrc1),
            .i_psrc2_vld   (create_psrc2_vld),
            .i_psrc2_ready (create_psrc2_ready),
            .i_psrc2       (create_psrc2),
            .i_pdst_vld    (create_pdst_vld),
            .i_pdst        (create_pdst),
            .i_wake_vld    (wake_vld),
            .i_wake_preg   (wake_preg),
            .o_vld         (w_vld[g]),
            .o_ready       (w_ready[g]),
            .o_iid         (w_iid[g]),
            .o_payload     (w_payload[g]),
            .o_psrc1       (w_psrc1[g]),
            .o_psrc2       (w_psrc2[g]),
            .o_pdst_vld    (w_pdst_vld[g]),
            .o_pdst        (w_pdst[g])
        );
    end

endmodule

// File: tb/tb_idu_is_iq.sv
// Bench for idu_is_iq: directed scenarios plus random traffic against an
// age-ordered list model of the queue.
module tb_idu_is_iq;

    localparam int DEPTH = 8;
    localparam int WP    = 10;
    localparam int PW    = 6;
    localparam int IW    = 4;
    localparam int PLW   = 145;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst_clk;
    logic            rtu_global_flush;
    logic            create_vld;
    logic            create_rdy;
    logic [IW-1:0]   create_iid;
    logic [PLW-1:0]  create_payload;
    logic            create_psrc1_vld, create_psrc2_vld;
    logic            create_psrc1_ready, create_psrc2_ready;
    logic [PW-1:0]   create_psrc1, create_psrc2;
    logic            create_pdst_vld;
    logic [PW-1:0]   create_pdst;
    logic [WP-1:0]   wake_vld;
    logic [WP*PW-1:0] wake_preg;
    logic            issue_en;
    logic            issue_vld;
    logic [IW-1:0]   issue_iid;
    logic [PLW-1:0]  issue_payload;
    logic [PW-1:0]   issue_psrc1, issue_psrc2;
    logic            issue_pdst_vld;
    logic [PW-1:0]   issue_pdst;
    logic [CW-1:0]   entry_cnt;
    logic            empty;

    idu_is_iq #(.DEPTH(DEPTH), .WAKE_PORTS(WP)) dut (
        .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
        .create_vld(create_vld), .create_rdy(create_rdy), .create_iid(create_iid),
        .create_payload(create_payload),
        .create_psrc1_vld(create_psrc1_vld), .create_psrc2_vld(create_psrc2_vld),
        .create_psrc1_ready(create_psrc1_ready), .create_psrc2_ready(create_psrc2_ready),
        .create_psrc1(create_psrc1), .create_psrc2(create_psrc2),
        .create_pdst_vld(create_pdst_vld), .create_pdst(create_pdst),
        .wake_vld(wake_vld), .wake_preg(wake_preg), .issue_en(issue_en),
        .issue_vld(issue_vld), .issue_iid(issue_iid), .issue_payload(issue_payload),
        .issue_psrc1(issue_psrc1), .issue_psrc2(issue_psrc2),
        .issue_pdst_vld(issue_pdst_vld), .issue_pdst(issue_pdst),
        .entry_cnt(entry_cnt), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0]  iid;
        logic [PLW-1:0] pl;
        logic s1v, s1r, s2v, s2r, dv;
        logic [PW-1:0] s1, s2, d;
    } ent_t;

    typedef struct packed {
        logic           vld;
        logic [IW-1:0]  iid;
        logic [PLW-1:0] pl;
        logic [PW-1:0]  s1, s2;
        logic           dv;
        logic [PW-1:0]  d;
        logic [CW-1:0]  cnt;
        logic           rdy;
    } exp_t;

    ent_t mdl[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic hit(input logic [PW-1:0] p);
        for (int k = 0; k < WP; k++)
            if (wake_vld[k] && wake_preg[k*PW +: PW] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Oldest ready entry is the first ready one in creation order.
    function automatic int msel();
        for (int i = 0; i < mdl.size(); i++)
            if ((mdl[i].s1r || !mdl[i].s1v) && (mdl[i].s2r || !mdl[i].s2v)) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("issue_vld", 160'(issue_vld), 160'(mon_e.vld));
            chk("entry_cnt", 160'(entry_cnt), 160'(mon_e.cnt));
            chk("create_rdy", 160'(create_rdy), 160'(mon_e.rdy));
            chk("empty", 160'(empty), 160'(mon_e.cnt == 0));
            if (issue_vld && mon_e.vld) begin
                chk("issue_iid", 160'(issue_iid), 160'(mon_e.iid));
                chk("issue_payload", 160'(issue_payload), 160'(mon_e.pl));
                chk("issue_srcs", 160'({issue_psrc1, issue_psrc2}), 160'({mon_e.s1, mon_e.s2}));
                chk("issue_dst", 160'({issue_pdst_vld, issue_pdst}), 160'({mon_e.dv, mon_e.d}));
            end else if (!mon_e.vld) begin
                chk("idle_data", 160'({issue_iid, issue_psrc1, issue_psrc2, issue_pdst_vld, issue_pdst, issue_payload}), 160'(0));
            end
        end
    end

    // Push expectation for the current cycle, advance the model, then the clock.
    task automatic tick();
        exp_t e;
        ent_t n;
        int   s;
        bit   cf;
        s = msel();
        e = '0;
        e.cnt = CW'(mdl.size());
        e.rdy = (mdl.size() != DEPTH);
        if (s >= 0) begin
            e.vld = 1'b1; e.iid = mdl[s].iid; e.pl = mdl[s].pl;
            e.s1 = mdl[s].s1; e.s2 = mdl[s].s2; e.dv = mdl[s].dv; e.d = mdl[s].d;
        end
        exp_q.push_back(e);
        cf = create_vld && (mdl.size() != DEPTH);
        n.iid = create_iid; n.pl = create_payload;
        n.s1v = create_psrc1_vld; n.s1r = create_psrc1_ready || hit(create_psrc1); n.s1 = create_psrc1;
        n.s2v = create_psrc2_vld; n.s2r = create_psrc2_ready || hit(create_psrc2); n.s2 = create_psrc2;
        n.dv = create_pdst_vld; n.d = create_pdst_vld ? create_pdst : '0;
        if (rtu_global_flush) begin
            mdl.delete();
        end else begin
            for (int i = 0; i < mdl.size(); i++) begin
                if (hit(mdl[i].s1)) mdl[i].s1r = 1'b1;
                if (hit(mdl[i].s2)) mdl[i].s2r = 1'b1;
            end
            if (s >= 0 && issue_en) mdl.delete(s);
            if (cf) mdl.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rtu_global_flush = 0; create_vld = 0; wake_vld = '0; issue_en = 0;
    endtask

    task automatic set_wake(input int port, input logic [PW-1:0] p);
        wake_vld[port] = 1'b1;
        wake_preg[port*PW +: PW] = p;
    endtask

    task automatic set_create(input logic [IW-1:0] iid,
                              input logic s1v, input logic s1r, input logic [PW-1:0] s1,
                              input logic s2v, input logic s2r, input logic [PW-1:0] s2,
                              input logic dv, input logic [PW-1:0] d);
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        create_vld = 1; create_iid = iid; create_payload = r[PLW-1:0];
        create_psrc1_vld = s1v; create_psrc1_ready = s1r; create_psrc1 = s1;
        create_psrc2_vld = s2v; create_psrc2_ready = s2r; create_psrc2 = s2;
        create_pdst_vld = dv; create_pdst = d;
    endtask

    task automatic chk_reset_vals();
        chk("rst_cnt", 160'(entry_cnt), 160'(0));
        chk("rst_empty", 160'(empty), 160'(1));
        chk("rst_create_rdy", 160'(create_rdy), 160'(1));
        chk("rst_issue_vld", 160'(issue_vld), 160'(0));
        chk("rst_data", 160'({issue_iid, issue_psrc1, issue_psrc2, issue_pdst_vld, issue_pdst, issue_payload}), 160'(0));
    endtask

    initial begin
        rst_clk = 0;
        idle();
        wake_preg = '0;
        set_create(0, 0, 0, 0, 0, 0, 0, 0, 0);
        create_vld = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        rst_clk = 1;
        @(posedge clk); #1;

        // 1: wake one cycle after create
        set_create(1, 1, 0, 5, 0, 0, 0, 1, 7); tick();
        idle(); set_wake(3, 5); tick();
        idle(); issue_en = 1; tick();
        idle(); tick();

        // 2: in-order issue of ready entries with hold
        set_create(2, 1, 1, 1, 1, 1, 2, 1, 3); tick();
        set_create(3, 0, 0, 0, 1, 1, 4, 0, 9); tick();
        set_create(4, 1, 1, 6, 0, 0, 0, 1, 8); tick();
        idle(); tick(); tick();
        issue_en = 1; tick(); tick(); tick();
        idle(); tick();

        // 3: full queue, create dropped against same-cycle issue
        for (int i = 0; i < DEPTH; i++) begin
            set_create(IW'(i), 1, 1, PW'(i), 1, 1, PW'(i+1), 1, PW'(i+2)); tick();
        end
        set_create(15, 0, 0, 0, 0, 0, 0, 0, 0); issue_en = 1; tick();
        idle(); tick();
        issue_en = 1; repeat (DEPTH) tick();
        idle(); tick();

        // 4: same-cycle wake on create
        set_create(5, 1, 0, 9, 0, 0, 0, 1, 1); set_wake(0, 9); tick();
        idle(); tick();
        issue_en = 1; tick();
        idle(); tick();

        // 5: flush with create
        for (int i = 0; i < 4; i++) begin
            set_create(IW'(i+6), 1, 0, 50, 0, 0, 0, 0, 0); tick();
        end
        set_create(12, 0, 0, 0, 0, 0, 0, 1, 2); rtu_global_flush = 1; issue_en = 1; tick();
        idle(); tick();

        // 6: age priority
        set_create(10, 1, 0, 20, 0, 0, 0, 1, 4); tick();
        set_create(11, 0, 0, 0, 0, 0, 0, 1, 5); tick();
        idle(); issue_en = 1; tick();
        set_create(12, 1, 0, 21, 0, 0, 0, 1, 6); tick();
        idle(); set_wake(1, 21); set_wake(2, 20); tick();
        idle(); issue_en = 1; tick(); tick();
        idle(); tick();

        // mid-operation asynchronous reset
        for (int i = 0; i < 3; i++) begin
            set_create(IW'(i), 0, 0, 0, 0, 0, 0, 1, 3); tick();
        end
        idle();
        rst_clk = 0;
        #1;
        chk_reset_vals();
        mdl.delete();
        #2;
        rst_clk = 1;
        @(posedge clk); #1;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 9) < 6)
                set_create(IW'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), PW'($urandom_range(0, 63)));
            for (int k = 0; k < WP; k++) begin
                wake_vld[k] = ($urandom_range(0, 5) == 0);
                wake_preg[k*PW +: PW] = PW'($urandom_range(0, 15));
            end
            issue_en = 1'($urandom_range(0, 1));
            rtu_global_flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        chk("exp_q_drained", 160'(exp_q.size()), 160'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
